teatris_leitor_pecas: RTL and testbench
=======================================

# teatris_leitor_pecas

Piece-pattern reader and serializer for TEAtris. On a start pulse it forms the 4-bit address from piece id and rotation and reads the 16-bit pattern from the piece ROM, which has one cycle of registered read latency. It checks the ROM's fixed fields, then shifts the pattern out MSB-first with a bit strobe and a latch pulse to the display driver. It is the consumer end of the piece ROM interface, sitting between game logic and display.

## Interface
- DIVISOR, 4: clock cycles per serial bit; legal range 1..255.
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- iniciar  in  1  start request; sampled only in OCIOSO.
- peca  in  2  piece id, 0..3.
- rotacao  in  2  rotation, 0..3.
- endereco  out  4  ROM address; registered, {peca, rotacao}.
- padrao_rom  in  16  ROM data; valid one edge after endereco changes.
- padrao_atual  out  16  last captured pattern.
- dado_serial  out  1  serial data, MSB first.
- pulso_bit  out  1  1-cycle strobe; the receiver samples dado_serial on the edge where pulso_bit=1.
- trava  out  1  1-cycle latch pulse after the 16th bit.
- ocupado  out  1  high from the acceptance edge until return to OCIOSO.
- erro_padrao  out  1  high if any fixed-field bit of the captured pattern is 0; held until the next accepted start.

## Operation
- FSM states: OCIOSO, LEITURA, CAPTURA, DESLOCA, TRAVA.
- OCIOSO:
  - When iniciar=1: endereco<={peca,rotacao}, ocupado<=1, erro_padrao<=0, go to LEITURA.
  - Otherwise hold.
- LEITURA: wait one cycle for the ROM to register its data; go to CAPTURA.
- CAPTURA:
  - Shift register and padrao_atual <= padrao_rom.
  - erro_padrao <= ((padrao_rom & 16'hE7E7) != 16'hE7E7). Fixed-one fields are bits 15:13, 10:5 and 2:0.
  - Clear bit counter (0..15) and divider counter (0..DIVISOR-1); go to DESLOCA.
- DESLOCA:
  - dado_serial = shift register bit 15.
  - Divider counts 0..DIVISOR-1; pulso_bit=1 when divider==DIVISOR-1.
  - On that edge: shift left by one, fill bit 0 with 0, increment bit counter.
  - After the strobe of bit 15, go to TRAVA.
- TRAVA:
  - trava=1 for one cycle, dado_serial=0.
  - Next edge: ocupado<=0, go to OCIOSO.
- iniciar is ignored while ocupado=1; pending requests are not queued.
- Counter widths: bit counter 4 bits; divider sized for DIVISOR-1 (8 bits sufficient).
- A detected error does not abort the transfer; the pattern is still shifted out.

## Timing
- Reset: state OCIOSO, endereco=0, padrao_atual=0, dado_serial=0, pulso_bit=0, trava=0, ocupado=0, erro_padrao=0, all counters 0.
- Reset asserted mid-transfer aborts immediately to the reset values; no trava is issued.
- Cycle numbering: the acceptance edge is E0; cycle k follows edge Ek.
- Cycle 0: LEITURA.
- Cycle 1: CAPTURA; padrao_rom is valid after E1.
- E2: capture happens; padrao_atual and erro_padrao are valid from cycle 2.
- Cycles 2 .. 1+16·DIVISOR: DESLOCA.
- Cycle 2+16·DIVISOR: TRAVA.
- ocupado falls at edge E(3+16·DIVISOR).
- The earliest next acceptance is at that same edge plus one.
- DIVISOR=1: pulso_bit stays high for all 16 DESLOCA cycles.
- pulso_bit and trava are never high in the same cycle.
- All outputs are registered except dado_serial and pulso_bit, which decode registered state only (no input-to-output paths).

## Test plan
- Reset, then peca=0, rotacao=2, ROM model returns 16'hF7F7 for address 2, DIVISOR=2 -> endereco=2 after E0; serial bits 1111_0111_1111_0111 with 16 strobes at cycles 3,5,…,33; trava at cycle 34; ocupado low after E35; erro_padrao=0.
- peca=1, rotacao=1 (address 5, 16'hEFE7), DIVISOR=1 -> strobes in cycles 2..17, bits 1110_1111_1110_0111; trava at cycle 18; padrao_atual=16'hEFE7.
- ROM model forced to 16'hE7E6 -> erro_padrao=1 from cycle 2; the full transfer still completes; erro_padrao is cleared on the next accepted iniciar.
- iniciar held high for the whole transfer with changing peca/rotacao -> exactly one transfer; endereco stays at the first value; a new transfer is accepted only in OCIOSO.
- reset_n pulsed low during DESLOCA (bit 7) -> all outputs at reset values asynchronously; no trava; the next iniciar starts cleanly at address {peca,rotacao}.
- Sweep all 16 addresses back-to-back, with iniciar asserted the cycle after ocupado falls -> each padrao_atual matches the ROM model; 16 trava pulses; no dropped requests.

Source files
------------

// File: rtl/teatris_leitor_pecas.sv
// Piece-pattern reader for TEAtris: fetches a 16-bit pattern from the piece ROM,
// validates its fixed-one fields and shifts it out MSB-first, then pulses a latch.
module teatris_leitor_pecas #(
  parameter int unsigned DIVISOR = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        iniciar,
  input  logic [1:0]  peca,
  input  logic [1:0]  rotacao,
  output logic [3:0]  endereco,
  input  logic [15:0] padrao_rom,
  output logic [15:0] padrao_atual,
  output logic        dado_serial,
  output logic        pulso_bit,
  output logic        trava,
  output logic        ocupado,
  output logic        erro_padrao
);

  typedef enum logic [2:0] {
    OCIOSO,
    LEITURA,
    CAPTURA,
    DESLOCA,
    TRAVA
  } estado_t;

  localparam logic [7:0]  DIV_LAST   = 8'(DIVISOR - 1);
  localparam logic [15:0] MASCARA_UM = 16'hE7E7;

  estado_t     estado_q, estado_d;
  logic [3:0]  endereco_q, endereco_d;
  logic [15:0] padrao_q, padrao_d;
  logic [15:0] desloc_q, desloc_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic        trava_q, trava_d;
  logic        ocupado_q, ocupado_d;
  logic        erro_q, erro_d;

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    padrao_d   = padrao_q;
    desloc_d   = desloc_q;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    trava_d    = 1'b0;
    ocupado_d  = ocupado_q;
    erro_d     = erro_q;
    unique case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          endereco_d = {peca, rotacao};
          ocupado_d  = 1'b1;
          erro_d     = 1'b0;
          estado_d   = LEITURA;
        end
      end
      LEITURA: estado_d = CAPTURA;
      CAPTURA: begin
        desloc_d  = padrao_rom;
        padrao_d  = padrao_rom;
        erro_d    = ((padrao_rom & MASCARA_UM) != MASCARA_UM);
        bit_cnt_d = '0;
        div_cnt_d = '0;
        estado_d  = DESLOCA;
      end
      DESLOCA: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          desloc_d  = {desloc_q[14:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            trava_d  = 1'b1;
            estado_d = TRAVA;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      TRAVA: begin
        ocupado_d = 1'b0;
        estado_d  = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      padrao_q   <= '0;
      desloc_q   <= '0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      trava_q    <= 1'b0;
      ocupado_q  <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      padrao_q   <= padrao_d;
      desloc_q   <= desloc_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      trava_q    <= trava_d;
      ocupado_q  <= ocupado_d;
      erro_q     <= erro_d;
    end
  end

  // Serial data and bit strobe decode registered state only.
  assign dado_serial  = (estado_q == DESLOCA) && desloc_q[15];
  assign pulso_bit    = (estado_q == DESLOCA) && (div_cnt_q == DIV_LAST);
  assign endereco     = endereco_q;
  assign padrao_atual = padrao_q;
  assign trava        = trava_q;
  assign ocupado      = ocupado_q;
  assign erro_padrao  = erro_q;

endmodule

// File: tb/tb_teatris_leitor_pecas.sv
// Bench for teatris_leitor_pecas: two instances (DIVISOR=2 and DIVISOR=1), each fed by
// a registered ROM model, checked cycle by cycle against a timeline derived from the pattern.
module tb_teatris_leitor_pecas;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [1:0]  iniciar;
  logic [1:0]  peca, rotacao;
  logic [3:0]  endereco     [2];
  logic [15:0] padrao_rom   [2];
  logic [15:0] padrao_atual [2];
  logic        dado_serial  [2];
  logic        pulso_bit    [2];
  logic        trava        [2];
  logic        ocupado      [2];
  logic        erro_padrao  [2];

  logic [15:0] rom [16];
  logic        rom_force;
  logic [15:0] last_pat [2];
  int          divs [2] = '{2, 1};
  int          checks = 0;
  int          failures = 0;
  int          trava_seen = 0;

  always @(posedge clock) begin
    padrao_rom[0] <= rom_force ? 16'hE7E6 : rom[endereco[0]];
    padrao_rom[1] <= rom_force ? 16'hE7E6 : rom[endereco[1]];
  end

  teatris_leitor_pecas #(.DIVISOR(2)) u_div2 (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar[0]), .peca(peca), .rotacao(rotacao),
    .endereco(endereco[0]), .padrao_rom(padrao_rom[0]), .padrao_atual(padrao_atual[0]),
    .dado_serial(dado_serial[0]), .pulso_bit(pulso_bit[0]), .trava(trava[0]),
    .ocupado(ocupado[0]), .erro_padrao(erro_padrao[0])
  );

  teatris_leitor_pecas #(.DIVISOR(1)) u_div1 (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar[1]), .peca(peca), .rotacao(rotacao),
    .endereco(endereco[1]), .padrao_rom(padrao_rom[1]), .padrao_atual(padrao_atual[1]),
    .dado_serial(dado_serial[1]), .pulso_bit(pulso_bit[1]), .trava(trava[1]),
    .ocupado(ocupado[1]), .erro_padrao(erro_padrao[1])
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_reset(input int s);
    chk("rst_endereco", endereco[s], 16'h0);
    chk("rst_padrao", padrao_atual[s], 16'h0);
    chk("rst_dado", dado_serial[s], 16'h0);
    chk("rst_pulso", pulso_bit[s], 16'h0);
    chk("rst_trava", trava[s], 16'h0);
    chk("rst_ocupado", ocupado[s], 16'h0);
    chk("rst_erro", erro_padrao[s], 16'h0);
  endtask

  // One transfer on instance s; returns one cycle after ocupado falls (state idle).
  task automatic run(input int s, input logic [1:0] p, input logic [1:0] r,
                     input bit hold, input int abort_c);
    int d = divs[s];
    int last = 3 + 16 * d;
    int idx;
    logic [3:0]  a = {p, r};
    logic [15:0] pat;
    logic        in_shift;
    iniciar[s] = 1'b1;
    peca = p;
    rotacao = r;
    @(posedge clock); #1;
    pat = rom_force ? 16'hE7E6 : rom[a];
    if (!hold) iniciar[s] = 1'b0;
    for (int c = 0; c <= last; c++) begin
      if (c == abort_c) begin
        reset_n = 1'b0;
        #1;
        chk_reset(s);
        reset_n = 1'b1;
        iniciar[s] = 1'b0;
        last_pat[0] = 16'h0;
        last_pat[1] = 16'h0;
        for (int k = 0; k < 4; k++) begin
          @(posedge clock); #1;
          chk("abort_trava", trava[s], 16'h0);
          chk("abort_ocupado", ocupado[s], 16'h0);
        end
        return;
      end
      in_shift = (c >= 2) && (c <= 1 + 16 * d);
      idx = 15 - (c - 2) / d;
      chk("endereco", endereco[s], {12'h0, a});
      chk("ocupado", ocupado[s], {15'h0, c <= 2 + 16 * d});
      chk("trava", trava[s], {15'h0, c == 2 + 16 * d});
      chk("pulso", pulso_bit[s], {15'h0, in_shift && ((c - 2) % d == d - 1)});
      chk("dado", dado_serial[s], {15'h0, in_shift && pat[idx[3:0]]});
      chk("padrao", padrao_atual[s], (c >= 2) ? pat : last_pat[s]);
      chk("erro", erro_padrao[s], {15'h0, (c >= 2) && ((pat & 16'hE7E7) != 16'hE7E7)});
      if (trava[s] === 1'b1) trava_seen++;
      if (hold) begin
        peca = 2'($urandom);
        rotacao = 2'($urandom);
      end
      if (c < last) begin
        @(posedge clock); #1;
      end
    end
    last_pat[s] = pat;
  endtask

  initial begin
    reset_n = 1'b0;
    iniciar = '0;
    peca = '0;
    rotacao = '0;
    rom_force = 1'b0;
    last_pat[0] = '0;
    last_pat[1] = '0;
    for (int i = 0; i < 16; i++)
      rom[i] = (i % 2 == 0) ? (16'($urandom) | 16'hE7E7) : 16'($urandom);
    rom[2] = 16'hF7F7;
    rom[5] = 16'hEFE7;
    repeat (3) @(posedge clock);
    #1;
    chk_reset(0);
    chk_reset(1);
    reset_n = 1'b1;
    @(posedge clock); #1;

    run(0, 2'd0, 2'd2, 1'b0, -1);
    run(1, 2'd1, 2'd1, 1'b0, -1);

    rom_force = 1'b1;
    run(0, 2'($urandom), 2'($urandom), 1'b0, -1);
    run(1, 2'($urandom), 2'($urandom), 1'b0, -1);
    rom_force = 1'b0;
    run(0, 2'd3, 2'd0, 1'b0, -1);
    run(1, 2'd2, 2'd2, 1'b0, -1);

    run(1, 2'd2, 2'd3, 1'b1, -1);
    run(1, 2'd0, 2'd1, 1'b0, -1);
    run(0, 2'd3, 2'd3, 1'b1, -1);
    run(0, 2'd1, 2'd0, 1'b0, -1);

    run(0, 2'd1, 2'd2, 1'b0, 2 + 7 * 2);
    run(0, 2'd1, 2'd2, 1'b0, -1);
    run(1, 2'd3, 2'd1, 1'b0, 2 + 7);
    run(1, 2'd3, 2'd1, 1'b0, -1);

    trava_seen = 0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] ad;
      ad = 4'(i);
      run(0, ad[3:2], ad[1:0], 1'b0, -1);
    end
    chk("sweep_trava_count", 16'(trava_seen), 16'd16);

    trava_seen = 0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] ad;
      ad = 4'($urandom);
      run(1, ad[3:2], ad[1:0], 1'b0, -1);
    end
    chk("rand_trava_count", 16'(trava_seen), 16'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
